// File: rtl/dbg_pkg.sv
// -----------------------------------------------------------------------------
// dbg_pkg
// Shared definitions for the debug command bridge:
//   - command opcodes (OP_WR / OP_RD) and response bytes (RSP_OK / RSP_ERR)
//   - bridge FSM state encoding
//   - is_opcode(): true for a byte that starts a valid command frame
// -----------------------------------------------------------------------------
package dbg_pkg;

    localparam logic [7:0] OP_WR   = 8'h57;  // 'W'
    localparam logic [7:0] OP_RD   = 8'h52;  // 'R'
    localparam logic [7:0] RSP_OK  = 8'h4B;  // 'K'
    localparam logic [7:0] RSP_ERR = 8'h45;  // 'E'

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DLO,
        ST_DHI,
        ST_EXEC,
        ST_RSP0,
        ST_RSP1
    } state_t;

    function automatic logic is_opcode(input logic [7:0] b);
        return (b == OP_WR) || (b == OP_RD);
    endfunction

endpackage

// File: rtl/dbg_timeout_ctr.sv
// -----------------------------------------------------------------------------
// dbg_timeout_ctr
// Saturating watchdog counter. Counts cycles while enabled; expired is high
// during the LIMIT-th enabled cycle since the last clear, so a transition
// taken on that edge lands exactly LIMIT cycles after counting started.
// Ports:
//   clk, rst_n  clock, synchronous active-low reset
//   clear       restart the count (wins over enable)
//   enable      count this cycle
//   expired     LIMIT cycles have elapsed (count holds there, never wraps)
// -----------------------------------------------------------------------------
module dbg_timeout_ctr #(
    parameter int LIMIT = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int             W    = $clog2(LIMIT);
    localparam logic [W-1:0]   LAST = W'(LIMIT - 1);

    logic [W-1:0] r_cnt;

    // NOTE: sequential state is assigned with <= so every flop samples the
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            r_cnt <= '0;
        end else if (enable && (r_cnt != LAST)) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    assign expired = (r_cnt == LAST);

endmodule

// File: rtl/dbg_cmd_bridge.sv
// -----------------------------------------------------------------------------
// dbg_cmd_bridge
// Parses 'W' addr dlo dhi / 'R' addr frames from the UART receiver, runs one
// strobe-and-wait cycle on the debug register bus, and returns 'K', the read
// data (lo, hi), or 'E' on bus timeout to the UART transmitter.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   rx_data, rx_valid     received byte stream (rx_valid is a 1-cycle pulse)
//   tx_data, tx_valid,    response byte stream, valid/ready handshake
//   tx_ready
//   dbg_a, dbg_di         bus address / write data (hold last latched value)
//   dbg_we, dbg_rd        bus strobes, held until dbg_ready or abort
//   dbg_do, dbg_ready     bus read data / cycle complete
//   busy                  FSM not idle
//   err                   1-cycle pulse on bus timeout
//   rx_drop               1-cycle pulse when a byte arrives during EXEC/RSP
// -----------------------------------------------------------------------------
module dbg_cmd_bridge
    import dbg_pkg::*;
#(
    parameter int BUS_TIMEOUT   = 1024,
    parameter int FRAME_TIMEOUT = 65535
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [7:0]  dbg_a,
    output logic [15:0] dbg_di,
    output logic        dbg_we,
    output logic        dbg_rd,
    input  logic [15:0] dbg_do,
    input  logic        dbg_ready,
    output logic        busy,
    output logic        err,
    output logic        rx_drop
);

    state_t      r_state;
    logic        r_is_wr;
    logic        r_bus_err;
    logic [7:0]  r_rd_hi;
    logic [7:0]  r_tx_data;
    logic        r_tx_valid;
    logic [7:0]  r_a;
    logic [15:0] r_di;
    logic        r_we;
    logic        r_rd;
    logic        r_busy;
    logic        r_err;
    logic        r_rx_drop;

    logic w_in_exec;
    logic w_in_frame;
    logic w_bus_exp;
    logic w_frame_exp;

    assign w_in_exec  = (r_state == ST_EXEC);
    assign w_in_frame = (r_state == ST_ADDR) || (r_state == ST_DLO) || (r_state == ST_DHI);

    // Bus watchdog: counts strobe cycles, restarts whenever EXEC is left.
    dbg_timeout_ctr #(.LIMIT(BUS_TIMEOUT)) u_bus_wd (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (!w_in_exec),
        .enable  (w_in_exec),
        .expired (w_bus_exp)
    );

    // Frame watchdog: counts idle cycles between bytes of a partial frame.
    dbg_timeout_ctr #(.LIMIT(FRAME_TIMEOUT)) u_frame_wd (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (!w_in_frame || rx_valid),
        .enable  (w_in_frame),
        .expired (w_frame_exp)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_is_wr    <= 1'b0;
            r_bus_err  <= 1'b0;
            r_rd_hi    <= '0;
            r_tx_data  <= '0;
            r_tx_valid <= 1'b0;
            r_a        <= '0;
            r_di       <= '0;
            r_we       <= 1'b0;
            r_rd       <= 1'b0;
            r_busy     <= 1'b0;
            r_err      <= 1'b0;
            r_rx_drop  <= 1'b0;
        end else begin
            r_err     <= 1'b0;
            r_rx_drop <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (rx_valid && is_opcode(rx_data)) begin
                        r_is_wr <= (rx_data == OP_WR);
                        r_state <= ST_ADDR;
                        r_busy  <= 1'b1;
                    end
                end

                // A received byte wins over a same-cycle frame expiry.
                ST_ADDR: begin
                    if (rx_valid) begin
                        r_a <= rx_data;
                        if (r_is_wr) begin
                            r_state <= ST_DLO;
                        end else begin
                            r_state <= ST_EXEC;
                            r_rd    <= 1'b1;
                        end
                    end else if (w_frame_exp) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end

                ST_DLO: begin
                    if (rx_valid) begin
                        r_di[7:0] <= rx_data;
                        r_state   <= ST_DHI;
                    end else if (w_frame_exp) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end

                ST_DHI: begin
                    if (rx_valid) begin
                        r_di[15:8] <= rx_data;
                        r_state    <= ST_EXEC;
                        r_we       <= 1'b1;
                    end else if (w_frame_exp) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end

                // dbg_ready on the last counted cycle beats the watchdog.
                ST_EXEC: begin
                    r_rx_drop <= rx_valid;
                    if (dbg_ready) begin
                        r_we       <= 1'b0;
                        r_rd       <= 1'b0;
                        r_bus_err  <= 1'b0;
                        r_rd_hi    <= dbg_do[15:8];
                        r_tx_data  <= r_is_wr ? RSP_OK : dbg_do[7:0];
                        r_tx_valid <= 1'b1;
                        r_state    <= ST_RSP0;
                    end else if (w_bus_exp) begin
                        r_we       <= 1'b0;
                        r_rd       <= 1'b0;
                        r_bus_err  <= 1'b1;
                        r_err      <= 1'b1;
                        r_tx_data  <= RSP_ERR;
                        r_tx_valid <= 1'b1;
                        r_state    <= ST_RSP0;
                    end
                end

                ST_RSP0: begin
                    r_rx_drop <= rx_valid;
                    if (tx_ready) begin
                        if (!r_is_wr && !r_bus_err) begin
                            r_tx_data <= r_rd_hi;
                            r_state   <= ST_RSP1;
                        end else begin
                            r_tx_valid <= 1'b0;
                            r_state    <= ST_IDLE;
                            r_busy     <= 1'b0;
                        end
                    end
                end

                ST_RSP1: begin
                    r_rx_drop <= rx_valid;
                    if (tx_ready) begin
                        r_tx_valid <= 1'b0;
                        r_state    <= ST_IDLE;
                        r_busy     <= 1'b0;
                    end
                end

                // NOTE: the 3-bit encoding has an unused value; recover to IDLE
                // rather than leaving the next state unspecified.
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign tx_data  = r_tx_data;
    assign tx_valid = r_tx_valid;
    assign dbg_a    = r_a;
    assign dbg_di   = r_di;
    assign dbg_we   = r_we;
    assign dbg_rd   = r_rd;
    assign busy     = r_busy;
    assign err      = r_err;
    assign rx_drop  = r_rx_drop;

endmodule
